argmax_classify: RTL and testbench

//  Final LeNet stage, directly downstream of the fc2 result collector.
//  - Takes the packed vector of OUTPUT_NODE signed fc2 scores.
//  - Scans the scores sequentially, one per cycle.
//  - Reports the winning class index (predicted digit) and its score with an en/finish handshake.

---
 rtl/argmax_classify.sv | 191 +++++++++++++++++++
 tb/tb_argmax_classify.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classify.sv
// argmax_classify: final LeNet stage. Scans OUTPUT_NODE signed fc2 scores,
// one per clock, and reports the winning class index and its score through
// an argmax_en / argmax_finish handshake.
// Optional feature macro: ARGMAX_MARGIN_EN adds the second-best tracker and
// the margin output (best minus second-best).
module argmax_classify #(
  parameter int OUTPUT_NODE = 10,
  parameter int DATA_SIZE   = 8,
  parameter int IDX_W       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             argmax_en,
  input  logic [DATA_SIZE*OUTPUT_NODE-1:0] result,
  output logic [IDX_W-1:0]                 class_id,
  output logic [DATA_SIZE-1:0]             max_score,
`ifdef ARGMAX_MARGIN_EN
  output logic [DATA_SIZE:0]               margin,
`endif
  output logic                             argmax_finish
);

  // Padded to a power of two so that any idx value selects a defined slot.
  localparam int NSLOT = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NODE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [DATA_SIZE*OUTPUT_NODE-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic signed [DATA_SIZE-1:0]      best_q, best_d;
  logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                 class_id_q, class_id_d;
  logic [DATA_SIZE-1:0]             max_score_q, max_score_d;
  logic                             finish_q, finish_d;
`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_SIZE-1:0]      second_q, second_d;
  logic [DATA_SIZE:0]               margin_q, margin_d;
  logic signed [DATA_SIZE-1:0]      new_second;
`endif

  logic signed [DATA_SIZE-1:0]      node_s [NSLOT];
  logic signed [DATA_SIZE-1:0]      cur_node;
  logic signed [DATA_SIZE-1:0]      live_node0;
  logic signed [DATA_SIZE-1:0]      new_best;
  logic [IDX_W-1:0]                 new_idx;
  logic                             take_new;

  // Unpack the captured score vector; node 0 sits in the most significant slice.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_node
      if (gi < OUTPUT_NODE) begin : g_real
        assign node_s[gi] = shadow_q[DATA_SIZE*(OUTPUT_NODE-gi)-1 -: DATA_SIZE];
      end else begin : g_pad
        assign node_s[gi] = '0;
      end
    end
  endgenerate

  assign live_node0 = result[DATA_SIZE*OUTPUT_NODE-1 -: DATA_SIZE];
  assign cur_node   = node_s[idx_q];

  // Compare step: strict greater-than so ties keep the lower index.
  always_comb begin
    take_new = (cur_node > best_q);
    new_best = best_q;
    new_idx  = best_idx_q;
    if (take_new) begin
      new_best = cur_node;
      new_idx  = idx_q;
    end
`ifdef ARGMAX_MARGIN_EN
    new_second = second_q;
    if (take_new) begin
      new_second = best_q;
    end else if (cur_node > second_q) begin
      new_second = cur_node;
    end
`endif
  end

  // Next-state and register-update logic for the scan controller.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_id_d  = class_id_q;
    max_score_d = max_score_q;
    finish_d    = finish_q;
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (argmax_en) begin
          shadow_d   = result;
          best_d     = live_node0;
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
          finish_d   = 1'b0;
`ifdef ARGMAX_MARGIN_EN
          second_d   = {1'b1, {(DATA_SIZE-1){1'b0}}};
`endif
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!argmax_en) begin
          // Aborted job: no result is published.
          finish_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          best_d     = new_best;
          best_idx_d = new_idx;
`ifdef ARGMAX_MARGIN_EN
          second_d   = new_second;
`endif
          if (idx_q == LAST_IDX) begin
            class_id_d  = new_idx;
            max_score_d = new_best;
`ifdef ARGMAX_MARGIN_EN
            margin_d    = {new_best[DATA_SIZE-1], new_best}
                        - {new_second[DATA_SIZE-1], new_second};
`endif
            finish_d    = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!argmax_en) begin
          finish_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        finish_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_id_q  <= '0;
      max_score_q <= '0;
      finish_q    <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_id_q  <= class_id_d;
      max_score_q <= max_score_d;
      finish_q    <= finish_d;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign class_id      = class_id_q;
  assign max_score     = max_score_q;
  assign argmax_finish = finish_q;
`ifdef ARGMAX_MARGIN_EN
  assign margin        = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classify.sv
// Self-checking bench for argmax_classify: table-driven directed jobs,
// hand-written abort/reset sequences and randomized jobs against a
// behavioural argmax model. Margin checks compile in with ARGMAX_MARGIN_EN.
module tb_argmax_classify;
  localparam int N  = 10;
  localparam int DW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          argmax_en;
  logic [DW*N-1:0] result;
  logic [IW-1:0] class_id;
  logic [DW-1:0] max_score;
  logic          argmax_finish;
`ifdef ARGMAX_MARGIN_EN
  logic [DW:0]   margin;
`endif

  argmax_classify #(.OUTPUT_NODE(N), .DATA_SIZE(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .argmax_en    (argmax_en),
    .result       (result),
    .class_id     (class_id),
    .max_score    (max_score),
`ifdef ARGMAX_MARGIN_EN
    .margin       (margin),
`endif
    .argmax_finish(argmax_finish)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW*N-1:0] scores;
    logic [IW-1:0]   cls;
    logic [DW-1:0]   mx;
    logic [DW:0]     mg;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: winner is the first occurrence of the maximum; margin is the
  // maximum minus the largest of the remaining nodes.
  task automatic model(input logic [DW*N-1:0] sc, output logic [IW-1:0] cls,
                       output logic [DW-1:0] mx, output logic [DW:0] mg);
    int s [N];
    int bi;
    int second;
    logic [DW-1:0] b;
    for (int i = 0; i < N; i++) begin
      b = sc[DW*(N-i)-1 -: DW];
      s[i] = int'($signed(b));
    end
    bi = 0;
    for (int i = 1; i < N; i++) if (s[i] > s[bi]) bi = i;
    second = -100000;
    for (int i = 0; i < N; i++) if (i != bi && s[i] > second) second = s[i];
    cls = IW'(bi);
    mx  = DW'(s[bi]);
    mg  = (DW+1)'(s[bi] - second);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full job: en held high until DONE, one extra hold cycle, then release.
  // mut_edge>0 changes the input vector after that edge.
  task automatic run_job(input string tag, input logic [DW*N-1:0] sc,
                         input logic [IW-1:0] ecls, input logic [DW-1:0] emx,
                         input logic [DW:0] emg, input int mut_edge,
                         input logic [DW*N-1:0] mut_sc);
    result    = sc;
    argmax_en = 1'b1;
    for (int e = 1; e <= N; e++) begin
      tick();
      if (e == mut_edge) result = mut_sc;
      if (e == N-1) chk({tag, " finish_early"}, 32'(argmax_finish), 32'd0);
    end
    chk({tag, " finish"}, 32'(argmax_finish), 32'd1);
    chk({tag, " class_id"}, 32'(class_id), 32'(ecls));
    chk({tag, " max_score"}, 32'(max_score), 32'(emx));
`ifdef ARGMAX_MARGIN_EN
    chk({tag, " margin"}, 32'(margin), 32'(emg));
`else
    if (emg != emg) $display("unreachable");
`endif
    tick();
    chk({tag, " hold_finish"}, 32'(argmax_finish), 32'd1);
    chk({tag, " hold_class"}, 32'(class_id), 32'(ecls));
    argmax_en = 1'b0;
    tick();
    chk({tag, " release"}, 32'(argmax_finish), 32'd0);
    chk({tag, " keep_class"}, 32'(class_id), 32'(ecls));
    $display("job %s: class_id=%0d max_score=0x%02h", tag, class_id, max_score);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " class_id0"}, 32'(class_id), 32'd0);
    chk({tag, " max0"}, 32'(max_score), 32'd0);
    chk({tag, " finish0"}, 32'(argmax_finish), 32'd0);
`ifdef ARGMAX_MARGIN_EN
    chk({tag, " margin0"}, 32'(margin), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] ecls;
    logic [DW-1:0] emx;
    logic [DW:0]   emg;
    logic [DW*N-1:0] sc;
    logic [DW-1:0] v;

    vecs[0] = '{scores: {8'd0,8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8,8'd9},
                cls: 4'd9, mx: 8'd9, mg: 9'd1};
    vecs[1] = '{scores: {{2{8'h80}}, 8'hF0, {7{8'h80}}},
                cls: 4'd2, mx: 8'hF0, mg: 9'd112};
    vecs[2] = '{scores: {{4{8'h00}}, 8'h40, {2{8'h00}}, 8'h40, {2{8'h00}}},
                cls: 4'd4, mx: 8'h40, mg: 9'd0};
    vecs[3] = '{scores: {10{8'h80}}, cls: 4'd0, mx: 8'h80, mg: 9'd0};
    vecs[4] = '{scores: {8'h7F, {9{8'h80}}}, cls: 4'd0, mx: 8'h7F, mg: 9'd255};
    vecs[5] = '{scores: {{9{8'h80}}, 8'h7F}, cls: 4'd9, mx: 8'h7F, mg: 9'd255};

    rst = 1'b1;
    argmax_en = 1'b0;
    result = '0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    foreach (vecs[k])
      run_job($sformatf("vec%0d", k), vecs[k].scores, vecs[k].cls, vecs[k].mx,
              vecs[k].mg, 0, '0);

    // Mid-scan input change must not affect the captured job.
    run_job("mutate", {{3{8'h05}}, 8'h7F, {6{8'h05}}}, 4'd3, 8'h7F, 9'd122,
            3, {8'h7F, {9{8'h00}}});

    // Abort by dropping en during the scan: previous result (class 3) kept.
    result = {{5{8'h00}}, 8'h50, {4{8'h00}}};
    argmax_en = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    argmax_en = 1'b0;
    tick();
    chk("abort finish", 32'(argmax_finish), 32'd0);
    chk("abort class", 32'(class_id), 32'd3);
    chk("abort max", 32'(max_score), 32'h7F);
    tick();
    chk("abort idle finish", 32'(argmax_finish), 32'd0);
    run_job("restart", {{5{8'h00}}, 8'h50, {4{8'h00}}}, 4'd5, 8'h50, 9'd80, 0, '0);

    // Reset during scan.
    result = {8'h10, {9{8'h00}}};
    argmax_en = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    argmax_en = 1'b0;
    tick();
    chk_zero("rst_scan");
    rst = 1'b0;
    tick();
    chk_zero("rst_scan_idle");
    run_job("after_rst_scan", vecs[0].scores, 4'd9, 8'd9, 9'd1, 0, '0);

    // Reset while in DONE.
    result = vecs[1].scores;
    argmax_en = 1'b1;
    for (int e = 1; e <= N; e++) tick();
    chk("rst_done pre finish", 32'(argmax_finish), 32'd1);
    rst = 1'b1;
    argmax_en = 1'b0;
    tick();
    chk_zero("rst_done");
    rst = 1'b0;
    tick();
    run_job("after_rst_done", vecs[2].scores, 4'd4, 8'h40, 9'd0, 0, '0);

    // Randomized jobs; half use a narrow value range to provoke ties.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++) begin
        if (j % 2 == 0) v = DW'($urandom_range(0, 255));
        else            v = DW'($urandom_range(0, 3)) + 8'hFE;
        sc[DW*(N-i)-1 -: DW] = v;
      end
      model(sc, ecls, emx, emg);
      run_job($sformatf("rand%0d", j), sc, ecls, emx, emg,
              (j % 5 == 0) ? 4 : 0, ~sc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
